// File: rtl/alu_rs_pipe.sv
// alu_rs_pipe: ALU reservation station with CDB snooping, oldest-first issue and a back-pressured result register
`ifndef ALU_TYPE_WIDTH
`define ALU_TYPE_WIDTH 4
`define ALU_ADD  4'd0
`define ALU_ADDU 4'd1
`define ALU_SUB  4'd2
`define ALU_SUBU 4'd3
`define ALU_AND  4'd4
`define ALU_OR   4'd5
`define ALU_NOR  4'd6
`define ALU_XOR  4'd7
`define ALU_SLL  4'd8
`define ALU_SRL  4'd9
`define ALU_SRA  4'd10
`define ALU_ROR  4'd11
`define ALU_SEQ  4'd12
`define ALU_SLT  4'd13
`define ALU_SLTU 4'd14
`endif

module alu_rs_pipe #(
  parameter int ENTRIES = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W = 4,
  parameter int OP_W = `ALU_TYPE_WIDTH,
  parameter int CDB_PORTS = 2,
  parameter logic [TAG_W-1:0] TAG_INVALID = '1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  logic [TAG_W-1:0] in_target,
  input  logic [OP_W-1:0] in_op,
  input  logic [DATA_W-1:0] in_val1,
  input  logic [DATA_W-1:0] in_val2,
  input  logic [TAG_W-1:0] in_tag1,
  input  logic [TAG_W-1:0] in_tag2,
  input  logic [CDB_PORTS-1:0] cdb_valid,
  input  logic [CDB_PORTS*TAG_W-1:0] cdb_tag,
  input  logic [CDB_PORTS*DATA_W-1:0] cdb_val,
  output logic out_valid,
  input  logic out_ready,
  output logic [TAG_W-1:0] out_target,
  output logic [DATA_W-1:0] out_result,
  output logic [$clog2(ENTRIES):0] occupancy
);
  localparam int S = $clog2(DATA_W);
  localparam int IW = $clog2(ENTRIES);
  localparam int CW = IW + 1;

  logic [ENTRIES-1:0] v, rdy, sel;
  logic [ENTRIES-1:0] older [ENTRIES];
  logic [TAG_W-1:0] tgt [ENTRIES];
  logic [TAG_W-1:0] tag1 [ENTRIES];
  logic [TAG_W-1:0] tag2 [ENTRIES];
  logic [OP_W-1:0] op [ENTRIES];
  logic [DATA_W-1:0] val1 [ENTRIES];
  logic [DATA_W-1:0] val2 [ENTRIES];
  logic [IW-1:0] fidx, iidx;
  logic ins, iss;
  logic [DATA_W-1:0] a, b, res;
  logic [2*DATA_W-1:0] rot;

  // Ports are scanned high to low so the lowest matching port wins.
  function automatic logic [TAG_W+DATA_W-1:0] snoop(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    logic [TAG_W+DATA_W-1:0] r;
    r = {t, d};
    for (int p = CDB_PORTS - 1; p >= 0; p--)
      if (t != TAG_INVALID && cdb_valid[p] && cdb_tag[p*TAG_W +: TAG_W] == t)
        r = {TAG_INVALID, cdb_val[p*DATA_W +: DATA_W]};
    return r;
  endfunction

  assign in_ready = occupancy < CW'(ENTRIES);
  assign ins = in_valid && in_ready;

  always_comb begin
    rdy = '0;
    sel = '0;
    fidx = '0;
    iidx = '0;
    for (int i = 0; i < ENTRIES; i++)
      rdy[i] = v[i] && tag1[i] == TAG_INVALID && tag2[i] == TAG_INVALID;
    for (int i = 0; i < ENTRIES; i++) begin
      sel[i] = rdy[i];
      for (int j = 0; j < ENTRIES; j++)
        if (j != i && rdy[j] && older[j][i]) sel[i] = 1'b0;
    end
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (!v[i]) fidx = IW'(i);
    for (int i = 0; i < ENTRIES; i++)
      if (sel[i]) iidx = IW'(i);
    iss = |rdy && (!out_valid || out_ready);
  end

  always_comb begin
    a = val1[iidx];
    b = val2[iidx];
    rot = {b, b} >> a[S-1:0];
    case (op[iidx])
      `ALU_ADD, `ALU_ADDU: res = a + b;
      `ALU_SUB, `ALU_SUBU: res = a - b;
      `ALU_AND:  res = a & b;
      `ALU_OR:   res = a | b;
      `ALU_NOR:  res = ~(a | b);
      `ALU_XOR:  res = a ^ b;
      `ALU_SLL:  res = a << b[S-1:0];
      `ALU_SRL:  res = a >> b[S-1:0];
      `ALU_SRA:  res = $signed(a) >>> b[S-1:0];
      `ALU_ROR:  res = rot[DATA_W-1:0];
      `ALU_SEQ:  res = {{(DATA_W-1){1'b0}}, a == b};
      `ALU_SLT:  res = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
      `ALU_SLTU: res = {{(DATA_W-1){1'b0}}, a < b};
      default:   res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      v <= '0;
      occupancy <= '0;
      out_valid <= 1'b0;
      out_target <= TAG_INVALID;
      out_result <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++)
        if (v[i]) begin
          {tag1[i], val1[i]} <= snoop(tag1[i], val1[i]);
          {tag2[i], val2[i]} <= snoop(tag2[i], val2[i]);
        end
      if (ins) begin
        v[fidx] <= 1'b1;
        tgt[fidx] <= in_target;
        op[fidx] <= in_op;
        {tag1[fidx], val1[fidx]} <= snoop(in_tag1, in_val1);
        {tag2[fidx], val2[fidx]} <= snoop(in_tag2, in_val2);
        for (int j = 0; j < ENTRIES; j++) begin
          older[fidx][j] <= 1'b0;
          older[j][fidx] <= IW'(j) != fidx;
        end
      end
      if (iss) begin
        v[iidx] <= 1'b0;
        out_valid <= 1'b1;
        out_target <= tgt[iidx];
        out_result <= res;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_target <= TAG_INVALID;
      end
      occupancy <= occupancy + CW'(ins) - CW'(iss);
    end
  end
endmodule

// File: tb/tb_alu_rs_pipe.sv
// tb_alu_rs_pipe: directed scoreboard bench for alu_rs_pipe
`ifndef ALU_TYPE_WIDTH
`define ALU_TYPE_WIDTH 4
`define ALU_ADD  4'd0
`define ALU_ADDU 4'd1
`define ALU_SUB  4'd2
`define ALU_SUBU 4'd3
`define ALU_AND  4'd4
`define ALU_OR   4'd5
`define ALU_NOR  4'd6
`define ALU_XOR  4'd7
`define ALU_SLL  4'd8
`define ALU_SRL  4'd9
`define ALU_SRA  4'd10
`define ALU_ROR  4'd11
`define ALU_SEQ  4'd12
`define ALU_SLT  4'd13
`define ALU_SLTU 4'd14
`endif

module tb_alu_rs_pipe;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, in_ready, out_valid, out_ready = 0;
  logic [3:0] in_target = 0, in_op = 0, in_tag1 = 4'hF, in_tag2 = 4'hF, out_target;
  logic [31:0] in_val1 = 0, in_val2 = 0, out_result;
  logic [1:0] cdb_valid = 0;
  logic [7:0] cdb_tag = 0;
  logic [63:0] cdb_val = 0;
  logic [2:0] occupancy;
  int cyc = 0, checks = 0, errors = 0;

  typedef struct {logic [3:0] tgt; logic [31:0] res; int cyc;} exp_t;
  exp_t q[$];

  typedef struct {logic [3:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] r;} vec_t;
  vec_t vecs[16] = '{
    '{`ALU_SUB,  32'd3,         32'd5,         32'hFFFF_FFFE},
    '{`ALU_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000},
    '{`ALU_OR,   32'h0F0F_0000, 32'h0000_F0F0, 32'h0F0F_F0F0},
    '{`ALU_NOR,  32'h0,         32'h0,         32'hFFFF_FFFF},
    '{`ALU_XOR,  32'hAAAA_AAAA, 32'hFFFF_0000, 32'h5555_AAAA},
    '{`ALU_SLL,  32'd1,         32'd35,        32'd8},
    '{`ALU_SRL,  32'h8000_0000, 32'd4,         32'h0800_0000},
    '{`ALU_SRA,  32'h8000_0000, 32'd4,         32'hF800_0000},
    '{`ALU_ROR,  32'd4,         32'h1234_5678, 32'h8123_4567},
    '{`ALU_SEQ,  32'd7,         32'd7,         32'd1},
    '{`ALU_SEQ,  32'd7,         32'd8,         32'd0},
    '{`ALU_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1},
    '{`ALU_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0},
    '{`ALU_ADDU, 32'hFFFF_FFFF, 32'd2,         32'd1},
    '{`ALU_SUBU, 32'd10,        32'd3,         32'd7},
    '{4'd15,     32'd123,       32'd45,        32'd0}
  };

  alu_rs_pipe dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_target(in_target), .in_op(in_op), .in_val1(in_val1), .in_val2(in_val2),
    .in_tag1(in_tag1), .in_tag2(in_tag2), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_val(cdb_val), .out_valid(out_valid), .out_ready(out_ready),
    .out_target(out_target), .out_result(out_result), .occupancy(occupancy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (!rst && !flush && out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got tgt=%0d res=%h, none expected", out_target, out_result);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (out_target !== e.tgt || out_result !== e.res || (e.cyc >= 0 && cyc != e.cyc)) begin
          errors++;
          $display("FAIL result: got tgt=%0d res=%h cyc=%0d, expected tgt=%0d res=%h cyc=%0d",
                   out_target, out_result, cyc, e.tgt, e.res, e.cyc);
        end
      end
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push(input logic [3:0] t, input logic [31:0] r, input int c);
    q.push_back('{t, r, c});
  endtask

  task automatic ins(input logic [3:0] t, input logic [3:0] o, input logic [31:0] v1, input logic [3:0] t1,
                     input logic [31:0] v2, input logic [3:0] t2);
    in_valid = 1; in_target = t; in_op = o;
    in_val1 = v1; in_tag1 = t1; in_val2 = v2; in_tag2 = t2;
    tick();
    in_valid = 0;
  endtask

  task automatic cdb(input logic [1:0] vld, input logic [3:0] t0, input logic [31:0] d0,
                     input logic [3:0] t1, input logic [31:0] d1);
    cdb_valid = vld; cdb_tag = {t1, t0}; cdb_val = {d1, d0};
  endtask

  initial begin
    int k;
    repeat (3) tick();
    rst = 0;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_target", 32'(out_target), 32'hF);
    chk("rst_out_result", out_result, 0);
    chk("rst_occupancy", 32'(occupancy), 0);
    chk("rst_in_ready", 32'(in_ready), 1);

    out_ready = 1;
    ins(3, `ALU_ADD, 5, 4'hF, 7, 4'hF);
    push(3, 12, cyc + 1);
    tick(); tick();
    chk("add_occ_back_to_0", 32'(occupancy), 0);

    for (int i = 0; i < 16; i++) begin
      ins(4'(i % 15), vecs[i].op, vecs[i].a, 4'hF, vecs[i].b, 4'hF);
      push(4'(i % 15), vecs[i].r, cyc + 1);
    end
    tick(); tick();

    ins(1, `ALU_SUB, 0, 6, 2, 4'hF);
    repeat (3) tick();
    cdb(2'b10, 0, 0, 6, 10);
    tick();
    push(1, 8, cyc + 1);
    cdb(0, 0, 0, 0, 0);
    tick(); tick();

    ins(4, `ALU_ADD, 0, 8, 1, 4'hF);
    ins(5, `ALU_ADD, 0, 9, 2, 4'hF);
    ins(6, `ALU_ADD, 0, 8, 3, 4'hF);
    ins(7, `ALU_ADD, 0, 9, 4, 4'hF);
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_occ", 32'(occupancy), 4);
    ins(12, `ALU_ADD, 1, 4'hF, 1, 4'hF);
    chk("full_ignored_occ", 32'(occupancy), 4);
    cdb(2'b11, 9, 100, 8, 200);
    tick();
    cdb(0, 0, 0, 0, 0);
    push(4, 201, cyc + 1); push(5, 102, cyc + 2);
    push(6, 203, cyc + 3); push(7, 104, cyc + 4);
    repeat (6) tick();
    chk("wake_drained_occ", 32'(occupancy), 0);

    ins(10, `ALU_ADD, 0, 13, 0, 4'hF);
    cdb(2'b11, 13, 1, 13, 2);
    tick();
    cdb(0, 0, 0, 0, 0);
    push(10, 1, cyc + 1);
    tick(); tick();

    out_ready = 0;
    ins(2, `ALU_OR, 32'h10, 4'hF, 1, 4'hF);
    ins(3, `ALU_SUB, 100, 4'hF, 1, 4'hF);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_target", 32'(out_target), 2);
      chk("bp_result", out_result, 32'h11);
      chk("bp_waiting_occ", 32'(occupancy), 1);
    end
    out_ready = 1;
    push(2, 32'h11, cyc); push(3, 99, cyc + 1);
    tick(); tick(); tick();

    cdb(2'b01, 9, 32'hFFFF_FFFF, 0, 0);
    ins(5, `ALU_ADD, 0, 9, 1, 4'hF);
    cdb(0, 0, 0, 0, 0);
    push(5, 0, cyc + 1);
    tick(); tick();

    out_ready = 0;
    ins(6, `ALU_AND, 32'hFF, 4'hF, 32'h0F, 4'hF);
    ins(7, `ALU_ADD, 0, 1, 0, 4'hF);
    ins(8, `ALU_ADD, 0, 2, 0, 4'hF);
    ins(9, `ALU_ADD, 0, 3, 0, 4'hF);
    chk("pre_flush_valid", 32'(out_valid), 1);
    chk("pre_flush_occ", 32'(occupancy), 3);
    flush = 1;
    tick();
    flush = 0;
    chk("flush_out_valid", 32'(out_valid), 0);
    chk("flush_out_target", 32'(out_target), 32'hF);
    chk("flush_occ", 32'(occupancy), 0);
    chk("flush_in_ready", 32'(in_ready), 1);
    out_ready = 1;
    cdb(2'b11, 1, 5, 2, 6);
    tick();
    cdb(2'b01, 3, 7, 0, 0);
    tick();
    cdb(0, 0, 0, 0, 0);
    repeat (3) tick();
    chk("post_flush_idle", 32'(out_valid), 0);

    k = 0;
    while (q.size() != 0 && k < 50) begin
      tick();
      k++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results still expected, 0 required", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
